camera64x64_host: RTL and testbench
===================================

# camera64x64_host

Host-side SPI reader for the 64x64 camera. It pairs with the camera's interrupt/lookup outputs: it drives SCLK/CS_N, shifts in one frame of pixel bytes from MISO, and then waits for the camera's INT before fetching the next frame. It tags each frame with the camera's LOOKUP state and streams pixels to downstream logic as byte/valid pulses. A watchdog restarts reads when the camera stays silent; this also covers the first read after enable, which is needed because the camera only raises INT after an SPI burst.

## Interface
- DIV, 4: SCLK half-period in CLK cycles (>= 1).
- NBYTE, 4096: bytes per frame (64x64 pixels, 8 bits each); >= 1.
- TIMEOUT, 32'h00005DC8: cycles in WAIT_INT before a forced read (about 2 ms at 12 MHz).
- CLK  in  1  system clock.
- RST  in  1  reset, asynchronous, active-high.
- EN  in  1  enable. Level. Low forces IDLE.
- INT  in  1  camera interrupt. Asynchronous, 2-flop synchronized.
- LOOKUP  in  1  camera lookup flag. Asynchronous, 2-flop synchronized.
- MISO  in  1  camera serial data. Asynchronous, 2-flop synchronized.
- SCLK  out  1  SPI clock, mode 0, idle low.
- CS_N  out  1  SPI chip select, active low.
- PIX_DATA  out  8  last received byte, MSB first on the wire.
- PIX_VALID  out  1  1-cycle pulse: PIX_DATA is new.
- FRAME_TAG  out  1  synchronized LOOKUP captured at the frame trigger.
- FRAME_DONE  out  1  1-cycle pulse at the end of a complete frame.
- TMO  out  1  1-cycle pulse when the watchdog forces a read.
- BUSY  out  1  high in SETUP, SHIFT and HOLD.

## Operation
- States: IDLE, SETUP, SHIFT, HOLD, WAIT_INT.
- IDLE: CS_N=1, SCLK=0. EN high -> SETUP. The kick read takes the same path as a normal read.
- SETUP: CS_N=0, SCLK=0 for DIV cycles -> SHIFT.
- SHIFT bit period = 2*DIV cycles: SCLK high for DIV cycles, then low for DIV cycles.
  - Synchronized MISO is shifted in (MSB first) on the last CLK cycle of each high phase.
  - The 8th sample updates PIX_DATA and pulses PIX_VALID on the next cycle.
  - The byte counter counts 0..NBYTE-1. After the low phase of the last bit of byte NBYTE-1 -> HOLD.
- HOLD: CS_N=1, SCLK=0 for DIV cycles. FRAME_DONE pulses on the last HOLD cycle -> WAIT_INT.
- WAIT_INT:
  - A rising edge of synchronized INT -> SETUP, and FRAME_TAG <= synchronized LOOKUP.
  - The watchdog counter clears on entry and increments each cycle. When it reaches TIMEOUT-1: TMO pulse, FRAME_TAG <= synchronized LOOKUP, -> SETUP.
  - If an INT edge and the timeout occur in the same cycle, the INT edge wins and there is no TMO.
- The INT edge detector runs in every state, but edges are acted on only in WAIT_INT. Edges during IDLE, SETUP, SHIFT or HOLD are discarded and are not queued.
- INT already high on entry to WAIT_INT is not an edge. The block waits for a fresh edge or for the timeout.
- EN low in any state -> IDLE on the next edge: CS_N=1, SCLK=0, counters cleared. A partial frame is abandoned with no FRAME_DONE; bytes already emitted stand.
- Counters: bit counter 3 bits, byte counter $clog2(NBYTE+1) bits, phase counter $clog2(DIV+1) bits, watchdog 32 bits. None of them wraps within a frame.

## Timing
- Reset values:
  - State = IDLE.
  - SCLK=0, CS_N=1, PIX_DATA=8'h00.
  - PIX_VALID, FRAME_DONE, TMO, BUSY = 0.
  - FRAME_TAG=0.
  - All synchronizers and counters = 0.
- All outputs are registered; no combinational input-to-output path.
- INT latency: INT is sampled high at edge n; the synchronizer output is high after edge n+1; CS_N falls at edge n+2.
- The EN rise to CS_N low latency is 1 cycle. EN is a synchronous input.
- Frame length (CS_N low) = DIV + 16*DIV*NBYTE cycles. The HOLD gap is DIV cycles before WAIT_INT.
- PIX_VALID pulses are spaced exactly 16*DIV cycles apart within a frame.
- RST mid-frame: outputs return to reset values asynchronously.

## Test plan
- DIV=2, NBYTE=4, EN rise; camera model returns 8'hA5, 8'h3C, 8'h00, 8'hFF:
  - CS_N low 1 cycle after EN and for 2+128 cycles.
  - PIX_VALID pulses 32 cycles apart carrying A5, 3C, 00, FF.
  - FRAME_DONE pulses once; TMO stays 0.
- After FRAME_DONE, INT driven high with LOOKUP=1:
  - CS_N low 2 cycles after INT is first sampled high.
  - FRAME_TAG=1; BUSY high throughout the frame.
- TIMEOUT=100, INT held low after a frame: TMO pulses 100 cycles after WAIT_INT entry and SETUP follows. With INT rising exactly on that cycle instead: no TMO.
- INT pulses during SHIFT and INT held high entering WAIT_INT: no extra frame starts; the next read comes only from a fresh edge or from TMO.
- EN dropped after byte 2 of 4: CS_N=1 and SCLK=0 next cycle; no FRAME_DONE. EN re-raised -> a full 4-byte frame from byte 0.
- RST asserted mid-SHIFT with DIV=1: all outputs are at reset values immediately. After release with EN=1: a clean frame whose first PIX_DATA is correct.

Source files
------------

// File: rtl/camera64x64_host_if.sv
// Pin bundle between the 64x64 camera host reader and its environment.
// The host side uses the master modport; the camera/downstream side uses slave.
interface camera64x64_host_if;
    logic       EN;
    logic       INT;
    logic       LOOKUP;
    logic       MISO;
    logic       SCLK;
    logic       CS_N;
    logic [7:0] PIX_DATA;
    logic       PIX_VALID;
    logic       FRAME_TAG;
    logic       FRAME_DONE;
    logic       TMO;
    logic       BUSY;

    modport master (
        input  EN, INT, LOOKUP, MISO,
        output SCLK, CS_N, PIX_DATA, PIX_VALID, FRAME_TAG, FRAME_DONE, TMO, BUSY
    );

    modport slave (
        output EN, INT, LOOKUP, MISO,
        input  SCLK, CS_N, PIX_DATA, PIX_VALID, FRAME_TAG, FRAME_DONE, TMO, BUSY
    );
endinterface

// File: rtl/camera64x64_host.sv
// Host-side SPI frame reader for the 64x64 camera: reads NBYTE pixel bytes per
// frame, then waits for a fresh INT edge (or the watchdog) before the next read.
module camera64x64_host #(
    parameter int          DIV     = 4,
    parameter int          NBYTE   = 4096,
    parameter logic [31:0] TIMEOUT = 32'h0000_5DC8
) (
    input  logic               CLK,
    input  logic               RST,
    camera64x64_host_if.master bus
);
    localparam int PW = $clog2(DIV + 1);
    localparam int BW = $clog2(NBYTE + 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(DIV - 1);
    localparam logic [BW-1:0] BYTE_LAST  = BW'(NBYTE - 1);
    localparam logic [31:0]   WD_LAST    = TIMEOUT - 32'd1;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, WAIT_INT} state_t;

    // Bit 0 = INT, bit 1 = LOOKUP, bit 2 = MISO
    logic [2:0] async_in;
    logic [2:0] sync_s;
    assign async_in = {bus.MISO, bus.LOOKUP, bus.INT};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic s1_reg;
            logic s2_reg;
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    s1_reg <= 1'b0;
                    s2_reg <= 1'b0;
                end else begin
                    s1_reg <= async_in[gi];
                    s2_reg <= s1_reg;
                end
            end
            assign sync_s[gi] = s2_reg;
        end
    endgenerate

    logic int_s, lookup_s, miso_s;
    assign int_s    = sync_s[0];
    assign lookup_s = sync_s[1];
    assign miso_s   = sync_s[2];

    logic int_prev_reg;
    logic int_edge;
    assign int_edge = int_s & ~int_prev_reg;

    // The edge detector tracks INT in every state, so an edge that happened
    // outside WAIT_INT is already consumed by the time WAIT_INT is entered.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) int_prev_reg <= 1'b0;
        else     int_prev_reg <= int_s;
    end

    state_t        state_reg;
    logic [PW-1:0] phase_reg;
    logic [2:0]    bit_reg;
    logic [BW-1:0] byte_reg;
    logic [31:0]   wd_reg;
    logic [6:0]    shreg_reg;
    logic          sclk_reg, cs_n_reg, pix_valid_reg, frame_tag_reg;
    logic          frame_done_reg, tmo_reg, busy_reg;
    logic [7:0]    pix_data_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg      <= IDLE;
            phase_reg      <= '0;
            bit_reg        <= '0;
            byte_reg       <= '0;
            wd_reg         <= '0;
            shreg_reg      <= '0;
            sclk_reg       <= 1'b0;
            cs_n_reg       <= 1'b1;
            pix_data_reg   <= 8'h00;
            pix_valid_reg  <= 1'b0;
            frame_tag_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            tmo_reg        <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            pix_valid_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            tmo_reg        <= 1'b0;
            if (!bus.EN) begin
                state_reg <= IDLE;
                cs_n_reg  <= 1'b1;
                sclk_reg  <= 1'b0;
                busy_reg  <= 1'b0;
                phase_reg <= '0;
                bit_reg   <= '0;
                byte_reg  <= '0;
                wd_reg    <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        state_reg <= SETUP;
                        cs_n_reg  <= 1'b0;
                        busy_reg  <= 1'b1;
                        phase_reg <= '0;
                    end
                    SETUP: begin
                        if (phase_reg == PHASE_LAST) begin
                            phase_reg <= '0;
                            sclk_reg  <= 1'b1;
                            state_reg <= SHIFT;
                        end else begin
                            phase_reg <= phase_reg + 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (phase_reg != PHASE_LAST) begin
                            phase_reg <= phase_reg + 1'b1;
                        end else if (sclk_reg) begin
                            // End of high phase: sample, MSB first
                            phase_reg <= '0;
                            sclk_reg  <= 1'b0;
                            shreg_reg <= {shreg_reg[5:0], miso_s};
                            if (bit_reg == 3'd7) begin
                                pix_data_reg  <= {shreg_reg, miso_s};
                                pix_valid_reg <= 1'b1;
                            end
                        end else begin
                            phase_reg <= '0;
                            bit_reg   <= bit_reg + 1'b1;
                            if (bit_reg == 3'd7 && byte_reg == BYTE_LAST) begin
                                byte_reg       <= '0;
                                cs_n_reg       <= 1'b1;
                                state_reg      <= HOLD;
                                frame_done_reg <= (DIV == 1);
                            end else begin
                                if (bit_reg == 3'd7) byte_reg <= byte_reg + 1'b1;
                                sclk_reg <= 1'b1;
                            end
                        end
                    end
                    HOLD: begin
                        if (phase_reg == PHASE_LAST) begin
                            phase_reg <= '0;
                            busy_reg  <= 1'b0;
                            wd_reg    <= '0;
                            state_reg <= WAIT_INT;
                        end else begin
                            phase_reg      <= phase_reg + 1'b1;
                            frame_done_reg <= (DIV >= 2) && (phase_reg == PW'(DIV - 2));
                        end
                    end
                    WAIT_INT: begin
                        // A fresh INT edge beats a coincident timeout
                        if (int_edge || wd_reg == WD_LAST) begin
                            tmo_reg       <= !int_edge;
                            frame_tag_reg <= lookup_s;
                            state_reg     <= SETUP;
                            cs_n_reg      <= 1'b0;
                            busy_reg      <= 1'b1;
                            phase_reg     <= '0;
                        end else begin
                            wd_reg <= wd_reg + 32'd1;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign bus.SCLK       = sclk_reg;
    assign bus.CS_N       = cs_n_reg;
    assign bus.PIX_DATA   = pix_data_reg;
    assign bus.PIX_VALID  = pix_valid_reg;
    assign bus.FRAME_TAG  = frame_tag_reg;
    assign bus.FRAME_DONE = frame_done_reg;
    assign bus.TMO        = tmo_reg;
    assign bus.BUSY       = busy_reg;
endmodule

// File: tb/tb_camera64x64_host.sv
// Bench for camera64x64_host: a DIV=2 instance against a behavioural camera and
// a DIV=1 instance for the asynchronous-reset restart.
module tb_camera64x64_host;
    localparam int DA = 2;
    localparam int NB = 4;
    localparam int TO = 100;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    camera64x64_host_if ifa();
    camera64x64_host_if ifb();

    camera64x64_host #(.DIV(DA), .NBYTE(NB), .TIMEOUT(32'd100)) dut_a (
        .CLK(CLK), .RST(RST), .bus(ifa)
    );
    camera64x64_host #(.DIV(1), .NBYTE(NB), .TIMEOUT(32'd100)) dut_b (
        .CLK(CLK), .RST(RST), .bus(ifb)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Event recorder, sampled 1 time unit after each rising edge
    int         csn_fall_q[$], csn_rise_q[$], fd_a_q[$], tmo_a_q[$];
    int         pix_cyc_q[$], pix_b_cyc_q[$];
    logic [7:0] pix_a_q[$], pix_b_q[$];
    int         fd_b_n = 0;
    int         busy_bad = 0;
    logic       prev_csn_a = 1'b1;

    always @(posedge CLK) begin
        #1;
        if (prev_csn_a === 1'b1 && ifa.CS_N === 1'b0) csn_fall_q.push_back(cyc);
        if (prev_csn_a === 1'b0 && ifa.CS_N === 1'b1) csn_rise_q.push_back(cyc);
        prev_csn_a = ifa.CS_N;
        if (ifa.CS_N === 1'b0 && ifa.BUSY !== 1'b1) busy_bad++;
        if (ifa.PIX_VALID === 1'b1) begin
            pix_a_q.push_back(ifa.PIX_DATA);
            pix_cyc_q.push_back(cyc);
            $display("cyc %0d: A pixel %02h", cyc, ifa.PIX_DATA);
        end
        if (ifa.FRAME_DONE === 1'b1) begin
            fd_a_q.push_back(cyc);
            $display("cyc %0d: A frame done tag=%0b", cyc, ifa.FRAME_TAG);
        end
        if (ifa.TMO === 1'b1) begin
            tmo_a_q.push_back(cyc);
            $display("cyc %0d: A watchdog read", cyc);
        end
        if (ifb.PIX_VALID === 1'b1) begin
            pix_b_q.push_back(ifb.PIX_DATA);
            pix_b_cyc_q.push_back(cyc);
            $display("cyc %0d: B pixel %02h", cyc, ifb.PIX_DATA);
        end
        if (ifb.FRAME_DONE === 1'b1) begin
            fd_b_n++;
            $display("cyc %0d: B frame done", cyc);
        end
    end

    // Camera model: mode 0 slave, presents MSB on CS_N fall, next bit after each
    // SCLK fall; MISO idles high (pulled up) while deselected.
    logic [7:0] frame_a [NB];
    int   a_byte = 0, a_bit = 7;
    logic a_prev_sclk = 1'b0, a_prev_low = 1'b0;

    always @(negedge CLK) begin
        if (ifa.CS_N !== 1'b0) begin
            ifa.MISO = 1'b1;
        end else if (!a_prev_low) begin
            a_byte   = 0;
            a_bit    = 7;
            ifa.MISO = frame_a[0][7];
        end else if (a_prev_sclk && ifa.SCLK === 1'b0) begin
            if (a_bit == 0) begin
                a_byte++;
                a_bit = 7;
            end else begin
                a_bit--;
            end
            ifa.MISO = frame_a[a_byte % NB][a_bit];
        end
        a_prev_sclk = (ifa.SCLK === 1'b1);
        a_prev_low  = (ifa.CS_N === 1'b0);
    end

    logic [7:0] exp_q[$];

    task automatic fill_frame(input int nkeep);
        for (int i = 0; i < NB; i++) begin
            frame_a[i] = 8'($urandom_range(0, 255));
            if (i < nkeep) exp_q.push_back(frame_a[i]);
        end
    endtask

    function automatic int count_of(input int which);
        case (which)
            0: return fd_a_q.size();
            1: return tmo_a_q.size();
            2: return pix_a_q.size();
            3: return pix_b_q.size();
            4: return fd_b_n;
            5: return csn_fall_q.size();
            default: return 0;
        endcase
    endfunction

    task automatic wait_cnt(input string tag, input int which, input int n, input int budget);
        int k = 0;
        while (count_of(which) < n && k < budget) begin
            @(negedge CLK);
            k++;
        end
        check(tag, count_of(which) >= n, 1'b1);
    endtask

    task automatic wait_to_cyc(input int target);
        while (cyc < target) @(negedge CLK);
    endtask

    task automatic check_frame(input int pbase, input int ci, input int di);
        check("cs_low_len", csn_rise_q[ci] - csn_fall_q[ci], DA + 16 * DA * NB);
        check("done_pos", fd_a_q[di] - csn_rise_q[ci], DA - 1);
        for (int i = 0; i < NB; i++) begin
            check($sformatf("pix%0d", pbase + i), pix_a_q[pbase + i], exp_q[pbase + i]);
            if (i > 0) check("pix_gap", pix_cyc_q[pbase + i] - pix_cyc_q[pbase + i - 1], 16 * DA);
        end
    endtask

    int   k, t, nb;
    logic lk;

    initial begin
        ifa.EN = 1'b0; ifa.INT = 1'b0; ifa.LOOKUP = 1'b0;
        ifb.EN = 1'b0; ifb.INT = 1'b0; ifb.LOOKUP = 1'b0; ifb.MISO = 1'b1;
        #1 RST = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_csn", ifa.CS_N, 1'b1);
        check("rst_sclk", ifa.SCLK, 1'b0);
        check("rst_pix", ifa.PIX_DATA, 8'h00);
        check("rst_valid", ifa.PIX_VALID, 1'b0);
        check("rst_busy", ifa.BUSY, 1'b0);
        check("rst_tag", ifa.FRAME_TAG, 1'b0);
        check("rst_done", ifa.FRAME_DONE, 1'b0);
        check("rst_tmo", ifa.TMO, 1'b0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // Frame 1: EN-started kick read with fixed bytes
        frame_a = '{8'hA5, 8'h3C, 8'h00, 8'hFF};
        for (int i = 0; i < NB; i++) exp_q.push_back(frame_a[i]);
        k = cyc;
        ifa.EN = 1'b1;
        wait_cnt("f1_done", 0, 1, 400);
        check("en_to_csn", csn_fall_q[0] - k, 1);
        check_frame(0, 0, 0);
        check("f1_no_tmo", tmo_a_q.size(), 0);

        // Frame 2: INT edge with LOOKUP=1
        @(negedge CLK);
        check("wait_busy", ifa.BUSY, 1'b0);
        check("wait_csn", ifa.CS_N, 1'b1);
        fill_frame(NB);
        ifa.LOOKUP = 1'b1;
        ifa.INT = 1'b1;
        k = cyc;
        wait_cnt("f2_start", 5, 2, 20);
        check("int_to_csn", csn_fall_q[1] - k, 3);
        repeat (5) @(negedge CLK);
        ifa.INT = 1'b0;
        wait_cnt("f2_done", 0, 2, 400);
        check_frame(4, 1, 1);
        check("f2_tag", ifa.FRAME_TAG, 1'b1);

        // Frame 3: INT stays low, watchdog forces the read
        t = fd_a_q[1];
        ifa.LOOKUP = 1'b0;
        fill_frame(NB);
        wait_cnt("f3_tmo", 1, 1, 300);
        check("tmo_delay", tmo_a_q[0] - t, TO + 1);
        check("tmo_csn", csn_fall_q[2] - t, TO + 1);
        wait_cnt("f3_done", 0, 3, 400);
        check_frame(8, 2, 2);
        check("f3_tag", ifa.FRAME_TAG, 1'b0);

        // Frame 4: INT edge lands on the timeout cycle, edge wins
        t = fd_a_q[2];
        ifa.LOOKUP = 1'b1;
        fill_frame(NB);
        wait_to_cyc(t + TO - 2);
        ifa.INT = 1'b1;
        wait_cnt("f4_start", 5, 4, 50);
        check("race_csn", csn_fall_q[3] - t, TO + 1);
        // Bounce INT mid-SHIFT, then hold it high into WAIT_INT
        wait_cnt("f4_pix", 2, 13, 200);
        ifa.INT = 1'b0;
        repeat (6) @(negedge CLK);
        ifa.INT = 1'b1;
        wait_cnt("f4_done", 0, 4, 400);
        check("race_no_tmo", tmo_a_q.size(), 1);
        check_frame(12, 3, 3);
        check("f4_tag", ifa.FRAME_TAG, 1'b1);

        // Frame 5: no fresh edge, only the watchdog restarts; abandoned after byte 2
        t = fd_a_q[3];
        lk = 1'($urandom_range(0, 1));
        ifa.LOOKUP = lk;
        fill_frame(2);
        wait_cnt("f5_tmo", 1, 2, 300);
        check("held_int_tmo", tmo_a_q[1] - t, TO + 1);
        check("held_int_csn", csn_fall_q[4] - t, TO + 1);
        ifa.INT = 1'b0;
        wait_cnt("f5_pix", 2, 18, 200);
        ifa.EN = 1'b0;
        @(posedge CLK);
        #1;
        check("abort_csn", ifa.CS_N, 1'b1);
        check("abort_sclk", ifa.SCLK, 1'b0);
        check("abort_busy", ifa.BUSY, 1'b0);
        repeat (200) @(negedge CLK);
        check("abort_no_done", fd_a_q.size(), 4);
        check("abort_pix_cnt", pix_a_q.size(), 18);
        check("abort_no_tmo", tmo_a_q.size(), 2);
        check("f5_tag", ifa.FRAME_TAG, lk);
        for (int i = 16; i < 18; i++) check($sformatf("pix%0d", i), pix_a_q[i], exp_q[i]);

        // Frame 6: EN re-raised, full frame from byte 0
        fill_frame(NB);
        k = cyc;
        ifa.EN = 1'b1;
        wait_cnt("f6_done", 0, 5, 400);
        check("reen_csn", csn_fall_q[5] - k, 1);
        check_frame(18, 5, 4);
        check("busy_in_frame", busy_bad, 0);
        ifa.EN = 1'b0;

        // DIV=1: asynchronous reset mid-SHIFT, then a clean frame. The MISO
        // synchronizer delay equals a whole bit period here, so the line is held high.
        ifb.EN = 1'b1;
        wait_cnt("b_pix1", 3, 1, 100);
        repeat (3) @(negedge CLK);
        check("b_pix_pre", ifb.PIX_DATA, 8'hFF);
        check("b_sclk_run", ifb.CS_N, 1'b0);
        RST = 1'b1;
        #1;
        check("b_rst_csn", ifb.CS_N, 1'b1);
        check("b_rst_sclk", ifb.SCLK, 1'b0);
        check("b_rst_pix", ifb.PIX_DATA, 8'h00);
        check("b_rst_busy", ifb.BUSY, 1'b0);
        check("b_rst_valid", ifb.PIX_VALID, 1'b0);
        check("a_rst_pix", ifa.PIX_DATA, 8'h00);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        nb = pix_b_q.size();
        wait_cnt("b_pix_after", 3, nb + 1, 100);
        check("b_first_pix", pix_b_q[nb], 8'hFF);
        wait_cnt("b_done", 4, 1, 200);
        check("b_pix_cnt", pix_b_q.size() - nb, NB);
        check("b_pix_gap", pix_b_cyc_q[nb + 1] - pix_b_cyc_q[nb], 16);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
